multi_cycle_control_unit: RTL
=============================

# multi_cycle_control_unit

Multi-cycle control FSM for the 16-bit RISC computer, directly upstream of the register-file + ALU datapath. Owns the PC and instruction register and fetches 16-bit instructions over a request/acknowledge memory port. Decodes each instruction and drives the datapath's register addresses, immediate select, ALU B select, ALU control, ALUOut_CE and RF_Write_en cycle by cycle. Resolves conditional branches from the datapath's NZVC flags.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports (synchronous active-high reset):
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- Imem_Ack  in  1  instruction memory returns data this cycle
- Imem_Data  in  16  instruction word, valid when Imem_Ack=1
- NZVC  in  4  datapath flags: [3]=N, [2]=Z, [1]=V, [0]=C
- Imem_Req  out  1  fetch request
- PC_out  out  16  current PC, word address
- Instr  out  16  instruction register, drives datapath immediate logic
- Rd_to_RF  out  3  write address = IR[11:9]
- Rm_Rd_to_RF  out  3  read port A address
- Rn_to_RF  out  3  read port B address = IR[5:3]
- Imm_Sel  out  2  00 simm5, 01 simm8, 10 zimm8, 11 {imm8, Rd[7:0]}
- ALU_B_Sel  out  2  00 = RF port B, 01 = immediate; 10 and 11 are never driven
- ALU_Control  out  2  00 ADD, 01 ADC, 10 SUB, 11 SBC
- ALUOut_CE  out  1  ALU output/flag register enable
- RF_Write_en  out  1  register file write enable
- Illegal  out  1  sticky; set when a reserved opcode is decoded
- Halted  out  1  high in HALT state

## Operation
- Format: IR[15:12] opcode, [11:9] Rd, [8:6] Rm, [5:3] Rn, [7:0] imm8, [4:0] imm5, [11:8] branch condition.
- Opcodes:
  - 0000 ADD, 0001 ADC, 0010 SUB, 0011 SBC: A=Rm, B=Rn.
  - 0100 ADDI, 0101 SUBI: A=Rm, B=simm5.
  - 0110 ADDI8: A=Rd, B=simm8.
  - 0111 ADDU8: A=Rd, B=zimm8.
  - 1000 ADDT: A=Rd, B={imm8, Rd[7:0]}, ADD.
  - 1001 CMP: Rm−Rn; flags updated, no writeback.
  - 1100 BCC: branch on IR[11:8].
  - 1111 HALT.
  - 1010, 1011, 1101, 1110: reserved. Set Illegal and behave as NOP.
- Rm_Rd_to_RF = Rm for opcodes 0000–0101 and 1001; Rd for 0110–1000.
- Branch conditions: 0000 EQ (Z), 0001 NE, 0010 CS (C), 0011 CC, 0100 MI (N), 0101 PL, 0110 VS (V), 0111 VC, 1110 AL. All other codes are never-taken.
- Branch target = PC + sext(imm8), where PC has already been incremented past the BCC. 16-bit wrap-around.
- States: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH; plus HALT.
  - FETCH: Imem_Req=1. On Imem_Ack: IR←Imem_Data, PC←PC+1 (FFFF wraps to 0000), go to DECODE. Otherwise stay.
  - DECODE: BCC updates PC if taken, then FETCH. HALT opcode → HALT. Reserved opcode → FETCH. All others → EXECUTE.
  - EXECUTE: ALUOut_CE=1. CMP → FETCH; all others → WRITEBACK.
  - WRITEBACK: RF_Write_en=1, then FETCH.
  - HALT: absorbing; only rst exits.
- Address, Imm_Sel, ALU_B_Sel and ALU_Control outputs are decoded combinationally from IR and are stable from DECODE through WRITEBACK.
- Imem_Ack outside FETCH is ignored.

## Timing
- Reset values: state FETCH, PC=RESET_PC, IR=0000, Illegal=0, Halted=0. All enables are 0 and Imem_Req=0 while rst=1.
- Reset mid-instruction: instruction abandoned, no RF write; FETCH resumes the cycle after rst falls.
- Cycles after Imem_Ack: ALU ops 3 (DECODE, EXECUTE, WRITEBACK); CMP 2; BCC and reserved opcodes 1.
- ALUOut_CE and RF_Write_en are single-cycle pulses, never high in the same cycle.
- Branch flag evaluation uses NZVC sampled in DECODE, which reflects the last EXECUTE.

## Configuration
- RISC_BRANCH_EN defined: BCC is implemented as specified.
- RISC_BRANCH_EN undefined: opcode 1100 is reserved (sets Illegal, NOP), and the branch adder and condition logic are removed.

## Structure
- Package risc_ctrl_pkg holds the opcode localparams, state encoding, condition codes, and the Imm_Sel, ALU_B_Sel and ALU_Control encodings.
- Sub-module instr_decoder: combinational IR → datapath control fields, plus is_alu, is_cmp, is_branch, is_halt, is_illegal.
- Top level holds the FSM, PC, IR and the branch condition evaluator.

## Test plan
- Reset, Imem_Ack held 1 with Imem_Data=0x0AEA (ADD R5,R3,R5) → Imem_Req asserted one cycle; Rd_to_RF=5, Rm_Rd_to_RF=3, Rn_to_RF=5; ALUOut_CE pulses 2 cycles after Ack; RF_Write_en pulses 3 cycles after Ack; PC_out=0001.
- 0x6C80 (ADDI8 R6,#-128) → Rm_Rd_to_RF=6, Imm_Sel=01, ALU_B_Sel=01, ALU_Control=00.
- 0x92E8 (CMP R3,R5) → ALUOut_CE pulses, RF_Write_en never asserts, back in FETCH 2 cycles after Ack.
- PC=0010, 0xC0FC (BEQ −4) with NZVC=0100 → PC_out=000D; same instruction with NZVC=0000 → PC_out=0011. With RISC_BRANCH_EN undefined → Illegal=1, PC_out=0011.
- 0xA000 → Illegal=1 and stays 1; next fetch proceeds normally. 0xF000 → Halted=1, Imem_Req stays 0 until rst.
- rst asserted during EXECUTE → no RF_Write_en; PC_out=RESET_PC; FETCH resumes.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the 16-bit RISC multi-cycle control unit: opcodes, FSM states,
// branch conditions and datapath select/control codes.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SBC   = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_SUBI  = 4'h5;
  localparam logic [3:0] OP_ADDI8 = 4'h6;
  localparam logic [3:0] OP_ADDU8 = 4'h7;
  localparam logic [3:0] OP_ADDT  = 4'h8;
  localparam logic [3:0] OP_CMP   = 4'h9;
  localparam logic [3:0] OP_BCC   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_AL = 4'hE;

  localparam logic [1:0] IMM_SIMM5 = 2'b00;
  localparam logic [1:0] IMM_SIMM8 = 2'b01;
  localparam logic [1:0] IMM_ZIMM8 = 2'b10;
  localparam logic [1:0] IMM_TOP8  = 2'b11;

  localparam logic [1:0] BSEL_RF  = 2'b00;
  localparam logic [1:0] BSEL_IMM = 2'b01;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_ADC = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SBC = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR decode into datapath control fields and instruction class flags.
// Opcode 1100 decodes as a branch only when RISC_BRANCH_EN is defined; otherwise it is reserved.
module instr_decoder
  import risc_ctrl_pkg::*;
(
  input  logic [15:0] instr,
  output logic [2:0]  rd,
  output logic [2:0]  rm_rd,
  output logic [2:0]  rn,
  output logic [1:0]  imm_sel,
  output logic [1:0]  alu_b_sel,
  output logic [1:0]  alu_control,
  output logic        is_alu,
  output logic        is_cmp,
  output logic        is_branch,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [3:0] opcode;

  assign opcode = instr[15:12];
  assign rd     = instr[11:9];
  assign rn     = instr[5:3];

  always_comb begin
    rm_rd       = instr[8:6];
    imm_sel     = IMM_SIMM5;
    alu_b_sel   = BSEL_RF;
    alu_control = ALU_ADD;
    is_alu      = 1'b0;
    is_cmp      = 1'b0;
    is_branch   = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OP_ADD:   is_alu = 1'b1;
      OP_ADC:   begin is_alu = 1'b1; alu_control = ALU_ADC; end
      OP_SUB:   begin is_alu = 1'b1; alu_control = ALU_SUB; end
      OP_SBC:   begin is_alu = 1'b1; alu_control = ALU_SBC; end
      OP_ADDI:  begin is_alu = 1'b1; alu_b_sel = BSEL_IMM; end
      OP_SUBI:  begin is_alu = 1'b1; alu_b_sel = BSEL_IMM; alu_control = ALU_SUB; end
      OP_ADDI8: begin is_alu = 1'b1; alu_b_sel = BSEL_IMM; imm_sel = IMM_SIMM8; rm_rd = instr[11:9]; end
      OP_ADDU8: begin is_alu = 1'b1; alu_b_sel = BSEL_IMM; imm_sel = IMM_ZIMM8; rm_rd = instr[11:9]; end
      OP_ADDT:  begin is_alu = 1'b1; alu_b_sel = BSEL_IMM; imm_sel = IMM_TOP8;  rm_rd = instr[11:9]; end
      OP_CMP:   begin is_cmp = 1'b1; alu_control = ALU_SUB; end
`ifdef RISC_BRANCH_EN
      OP_BCC:   is_branch = 1'b1;
`endif
      OP_HALT:  is_halt = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller owning PC and IR for the 16-bit RISC.
// Conditional branches (opcode 1100) exist only when RISC_BRANCH_EN is defined.
module multi_cycle_control_unit
  import risc_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Imem_Ack,
  input  logic [15:0] Imem_Data,
  input  logic [3:0]  NZVC,
  output logic        Imem_Req,
  output logic [15:0] PC_out,
  output logic [15:0] Instr,
  output logic [2:0]  Rd_to_RF,
  output logic [2:0]  Rm_Rd_to_RF,
  output logic [2:0]  Rn_to_RF,
  output logic [1:0]  Imm_Sel,
  output logic [1:0]  ALU_B_Sel,
  output logic [1:0]  ALU_Control,
  output logic        ALUOut_CE,
  output logic        RF_Write_en,
  output logic        Illegal,
  output logic        Halted
);

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] ir, ir_next;
  logic        illegal, illegal_next;
  logic        is_alu, is_cmp, is_branch, is_halt, is_illegal;
  logic        taken;
  logic [15:0] branch_target;

  instr_decoder u_decoder (
    .instr       (ir),
    .rd          (Rd_to_RF),
    .rm_rd       (Rm_Rd_to_RF),
    .rn          (Rn_to_RF),
    .imm_sel     (Imm_Sel),
    .alu_b_sel   (ALU_B_Sel),
    .alu_control (ALU_Control),
    .is_alu      (is_alu),
    .is_cmp      (is_cmp),
    .is_branch   (is_branch),
    .is_halt     (is_halt),
    .is_illegal  (is_illegal)
  );

`ifdef RISC_BRANCH_EN
  // pc already points past the BCC when the target is formed in DECODE
  assign branch_target = pc + {{8{ir[7]}}, ir[7:0]};

  always_comb begin
    taken = 1'b0;
    case (ir[11:8])
      CC_EQ:   taken = NZVC[2];
      CC_NE:   taken = ~NZVC[2];
      CC_CS:   taken = NZVC[0];
      CC_CC:   taken = ~NZVC[0];
      CC_MI:   taken = NZVC[3];
      CC_PL:   taken = ~NZVC[3];
      CC_VS:   taken = NZVC[1];
      CC_VC:   taken = ~NZVC[1];
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags  = ^NZVC;
  assign taken         = 1'b0;
  assign branch_target = pc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      ir      <= ir_next;
      illegal <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    ir_next      = ir;
    illegal_next = illegal;
    case (state)
      S_FETCH: begin
        if (Imem_Ack) begin
          ir_next    = Imem_Data;
          pc_next    = pc + 16'd1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt)              state_next = S_HALT;
        else if (is_alu || is_cmp) state_next = S_EXECUTE;
        else                      state_next = S_FETCH;
        if (is_branch && taken) pc_next = branch_target;
        if (is_illegal)         illegal_next = 1'b1;
      end
      S_EXECUTE:   state_next = is_cmp ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_next = S_FETCH;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_FETCH;
    endcase
  end

  // Enables are masked during rst so an abandoned instruction cannot write back
  assign Imem_Req    = ~rst && (state == S_FETCH);
  assign ALUOut_CE   = ~rst && (state == S_EXECUTE);
  assign RF_Write_en = ~rst && (state == S_WRITEBACK);
  assign Halted      = ~rst && (state == S_HALT);
  assign PC_out      = pc;
  assign Instr       = ir;
  assign Illegal     = illegal;

endmodule
